// File: rtl/sample_stream_gearbox_pkg.sv
// sample_stream_gearbox_pkg: FSM state type and width helpers for the sample gearbox.
package sample_stream_gearbox_pkg;
    typedef enum logic {RUN, FLUSH} state_t;

    function automatic int in_w(int bw, int n_prl);
        return bw * n_prl;
    endfunction

    function automatic int acc_w(int bw, int n_prl, int bw_out);
        return bw * n_prl + bw_out;
    endfunction

    function automatic int cnt_w(int bw, int n_prl, int bw_out);
        return $clog2(acc_w(bw, n_prl, bw_out) + 1);
    endfunction
endpackage

// File: rtl/sample_stream_gearbox.sv
// sample_stream_gearbox: packs N_PRL x BW sample beats into LSB-first BW_OUT words with frame-end padding.
module sample_stream_gearbox
    import sample_stream_gearbox_pkg::*;
#(
    parameter int BW     = 18,
    parameter int N_PRL  = 4,
    parameter int BW_OUT = 8
) (
    input  logic                          clk,
    input  logic                          srst_n,
    input  logic [N_PRL-1:0][BW-1:0]      s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic [BW_OUT-1:0]             m_data,
    output logic                          m_valid,
    output logic                          m_last,
    output logic [$clog2(BW_OUT)-1:0]     m_pad,
    input  logic                          m_ready
);
    localparam int IN_W  = in_w(BW, N_PRL);
    localparam int ACC_W = acc_w(BW, N_PRL, BW_OUT);
    localparam int CNT_W = cnt_w(BW, N_PRL, BW_OUT);
    localparam int PAD_W = $clog2(BW_OUT);

    state_t           state;
    logic [ACC_W-1:0] acc, acc_pop;
    logic [CNT_W-1:0] cnt, cnt_pop, take, pad_full;
    logic             push, pop, word_end;

    always_comb begin
        word_end = cnt <= CNT_W'(BW_OUT);
        s_ready  = state == RUN && word_end;
        m_valid  = cnt >= CNT_W'(BW_OUT) || (state == FLUSH && cnt != '0);
        m_data   = acc[BW_OUT-1:0];
        m_last   = state == FLUSH && word_end && cnt != '0;
        pad_full = CNT_W'(BW_OUT) - cnt;
        m_pad    = m_last ? pad_full[PAD_W-1:0] : '0;
        push     = s_valid && s_ready;
        pop      = m_valid && m_ready;
        take     = pop ? (word_end ? cnt : CNT_W'(BW_OUT)) : '0;
        cnt_pop  = cnt - take;
        acc_pop  = pop ? acc >> BW_OUT : acc;
    end

    // New beats land just above the surviving bits, so the word on m_data never moves during a stall.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
        end else begin
            acc   <= push ? acc_pop | (ACC_W'(s_data) << cnt_pop) : acc_pop;
            cnt   <= cnt_pop + (push ? CNT_W'(IN_W) : '0);
            state <= push && s_last ? FLUSH :
                     state == FLUSH && pop && word_end ? RUN : state;
        end
    end
endmodule

// File: tb/tb_sample_stream_gearbox.sv
// tb_sample_stream_gearbox: randomized scoreboard bench against a bit-queue packing model.
module tb_sample_stream_gearbox;
    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [2:0] p;
    } word_t;

    logic             clk = 0, srst_n = 0;
    logic [3:0][17:0] s_data = '0;
    logic             s_valid = 0, s_last = 0, s_ready;
    logic [7:0]       m_data;
    logic             m_valid, m_last, m_ready = 0;
    logic [2:0]       m_pad;

    logic [17:0]      s1_data = '0;
    logic             s1_valid = 0, s1_last = 0, s1_ready;
    logic [7:0]       m1_data;
    logic             m1_valid, m1_last, m1_ready = 1;
    logic [2:0]       m1_pad;

    int    n_pass = 0, n_chk = 0, cyc = 0, rmode = 0;
    word_t exp_q[$], tmp_q[$], got1[$];
    int    push_cyc[$], pop_cyc[$];
    logic [71:0] fb[4];
    bit    flushing = 0, prev_stall = 0;

    sample_stream_gearbox u_dut (
        .clk(clk), .srst_n(srst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_pad(m_pad), .m_ready(m_ready)
    );

    sample_stream_gearbox #(.BW(18), .N_PRL(1), .BW_OUT(8)) u_one (
        .clk(clk), .srst_n(srst_n), .s_data(s1_data), .s_valid(s1_valid), .s_last(s1_last),
        .s_ready(s1_ready), .m_data(m1_data), .m_valid(m1_valid), .m_last(m1_last),
        .m_pad(m1_pad), .m_ready(m1_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: stalled, 1: always ready, 2: random 50%
    always @(posedge clk) begin
        #2;
        m_ready = (rmode == 2) ? ($urandom_range(0, 1) == 1) : (rmode == 1);
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
    endtask

    // Reference: concatenate the frame LSB-first, zero-pad to a word multiple, slice into words.
    task automatic model_frame(input int nb, input int w);
        logic  bits[$];
        int    pad, nw;
        word_t x;
        tmp_q.delete();
        for (int k = 0; k < nb; k++)
            for (int i = 0; i < w; i++) bits.push_back(fb[k][i]);
        pad = (8 - bits.size() % 8) % 8;
        for (int i = 0; i < pad; i++) bits.push_back(1'b0);
        nw = bits.size() / 8;
        for (int j = 0; j < nw; j++) begin
            for (int i = 0; i < 8; i++) x.d[i] = bits[8*j+i];
            x.l = (j == nw - 1);
            x.p = x.l ? 3'(pad) : 3'd0;
            tmp_q.push_back(x);
        end
    endtask

    task automatic enqueue();
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
    endtask

    task automatic send(input logic [71:0] d, input logic l);
        bit done = 0;
        s_data = d; s_last = l; s_valid = 1;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        if (!done) chk("send_timeout", 0, 1);
        s_valid = 0; s_last = 0;
    endtask

    task automatic send1(input logic [17:0] d, input logic l);
        bit done = 0;
        s1_data = d; s1_last = l; s1_valid = 1;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (s1_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        if (!done) chk("send1_timeout", 0, 1);
        s1_valid = 0; s1_last = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_left", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!srst_n) begin
            exp_q.delete();
            flushing = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) chk("stall_hold_valid", int'(m_valid), 1);
            if (flushing) chk("no_accept_while_flushing", int'(s_ready), 0);
            if (s_valid && s_ready) begin
                push_cyc.push_back(cyc);
                if (s_last) flushing = 1;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) chk("extra_word", int'(m_data), -1);
                else begin
                    chk("m_data", int'(m_data), int'(exp_q[0].d));
                    chk("m_last", int'(m_last), int'(exp_q[0].l));
                    chk("m_pad", int'(m_pad), int'(exp_q[0].p));
                    if (m_ready) begin
                        pop_cyc.push_back(cyc);
                        if (m_last) flushing = 0;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
        end
    end

    always @(negedge clk)
        if (srst_n && m1_valid && m1_ready) got1.push_back({m1_data, m1_last, m1_pad});

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp, bq, nb;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_m_pad", int'(m_pad), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        srst_n = 1;
        @(posedge clk); #1;

        fb[0] = 72'h12345;
        model_frame(1, 72);
        chk("model_t1_len", tmp_q.size(), 9);
        chk("model_t1_w0", int'(tmp_q[0].d), 'h45);
        chk("model_t1_w1", int'(tmp_q[1].d), 'h23);
        chk("model_t1_w2", int'(tmp_q[2].d), 'h01);
        chk("model_t1_w8", int'({tmp_q[8].d, tmp_q[8].l, tmp_q[8].p}), 'h008);
        enqueue();
        rmode = 1;
        send(fb[0], 1);
        drain();

        bp = push_cyc.size(); bq = pop_cyc.size();
        for (int k = 0; k < 4; k++) fb[k] = 72'({$urandom(), $urandom(), $urandom()});
        model_frame(4, 72);
        chk("model_b2b_len", tmp_q.size(), 36);
        enqueue();
        for (int k = 0; k < 4; k++) send(fb[k], k == 3);
        drain();
        for (int k = 1; k < 4; k++) chk("beat_spacing", push_cyc[bp+k] - push_cyc[bp+k-1], 9);
        chk("b2b_word_count", pop_cyc.size() - bq, 36);
        chk("b2b_word_span", pop_cyc[pop_cyc.size()-1] - pop_cyc[bq], 35);

        for (int k = 0; k < 3; k++) fb[k] = 72'h3FFFF;
        model_frame(3, 18);
        chk("model_n1_len", tmp_q.size(), 7);
        chk("model_n1_w0", int'(tmp_q[0].d), 'hFF);
        chk("model_n1_w6", int'({tmp_q[6].d, tmp_q[6].l, tmp_q[6].p}), 'h3FA);
        for (int k = 0; k < 3; k++) send1(18'h3FFFF, k == 2);
        for (int t = 0; t < 200 && got1.size() < 7; t++) @(posedge clk);
        @(posedge clk); #1;
        chk("n1_count", got1.size(), 7);
        for (int i = 0; i < 7 && i < got1.size(); i++) chk("n1_word", int'(got1[i]), int'(tmp_q[i]));
        chk("n1_idle_ready", int'(s1_ready), 1);
        chk("n1_idle_valid", int'(m1_valid), 0);

        rmode = 2;
        for (int f = 0; f < 20; f++) begin
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) fb[k] = 72'({$urandom(), $urandom(), $urandom()});
            model_frame(nb, 72);
            enqueue();
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                send(fb[k], k == nb - 1);
            end
        end
        drain();

        rmode = 0;
        @(posedge clk); #3;
        fb[0] = 72'({$urandom(), $urandom(), $urandom()});
        model_frame(1, 72);
        enqueue();
        send(fb[0], 1);
        rmode = 1;
        repeat (4) @(posedge clk);
        #1 rmode = 0;
        #2;
        chk("pre_rst_valid", int'(m_valid), 1);
        chk("pre_rst_last", int'(m_last), 0);
        srst_n = 0;
        #1;
        chk("mid_rst_m_valid", int'(m_valid), 0);
        chk("mid_rst_m_last", int'(m_last), 0);
        chk("mid_rst_m_data", int'(m_data), 0);
        chk("mid_rst_m_pad", int'(m_pad), 0);
        chk("mid_rst_s_ready", int'(s_ready), 1);
        repeat (2) @(posedge clk);
        #1 srst_n = 1;
        for (int k = 0; k < 2; k++) fb[k] = 72'({$urandom(), $urandom(), $urandom()});
        model_frame(2, 72);
        enqueue();
        rmode = 1;
        for (int k = 0; k < 2; k++) send(fb[k], k == 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
